au_op_sequencer: RTL and testbench

Byte-stream front/back end for the 8-bit arithmetic unit. It accepts a 3-byte command frame (op, A, B) over a valid/ready input stream and drives the AU operand and control inputs from registers. After a settle interval it captures the AU result and carry, and presents them with a zero flag on a valid/ready output stream. It sits directly upstream of the AU, feeding it, and directly downstream of it, consuming R/C.

---
 rtl/au_op_sequencer_pkg.sv | 23 ++
 rtl/au_result_reg.sv | 21 ++
 rtl/au_op_sequencer.sv | 170 +++++++++++++++++
 tb/tb_au_op_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/au_op_sequencer_pkg.sv
// Shared definitions for the AU byte-stream sequencer: FSM state encodings,
// op-byte mask and the AU control codes it drives.
package au_op_sequencer_pkg;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    localparam logic [1:0] OP_MASK = 2'b11;

    // Control codes understood by the AU; the sequencer passes them through.
    localparam logic [1:0] AU_CTRL_0 = 2'b00;
    localparam logic [1:0] AU_CTRL_1 = 2'b01;
    localparam logic [1:0] AU_CTRL_2 = 2'b10;
    localparam logic [1:0] AU_CTRL_3 = 2'b11;

    localparam int unsigned SETTLE_CNT_W = 4;

endpackage

// File: rtl/au_result_reg.sv
// Load-enabled capture register with asynchronous active-low clear; one
// instance per captured output field (result, carry, zero).
module au_result_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/au_op_sequencer.sv
// Collects an (op, A, B) byte frame, drives the AU from registers, waits the
// settle interval, then captures R/C/Z and offers them on a valid/ready stream.
module au_op_sequencer
    import au_op_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] AU_A,
    output logic [WIDTH-1:0] AU_B,
    output logic [1:0]       AU_CONTROL,
    input  logic [WIDTH-1:0] AU_R,
    input  logic             AU_C,
    output logic [WIDTH-1:0] OUT_R,
    output logic             OUT_C,
    output logic             OUT_Z,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             BUSY,
    output logic [7:0]       OP_COUNT
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic                    ld_op;
    logic                    ld_a;
    logic                    ld_b;
    logic                    capture;
    logic                    out_xfer;
    logic                    au_zero;

    assign out_xfer = OUT_VALID && OUT_READY;
    assign au_zero  = (AU_R == '0);
    assign BUSY     = (state != S_OP);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_OP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        ld_op     = 1'b0;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        capture   = 1'b0;
        case (state)
            S_OP: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    ld_op     = 1'b1;
                    state_nxt = S_A;
                end
            end
            S_A: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    ld_a      = 1'b1;
                    state_nxt = S_B;
                end
            end
            S_B: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    ld_b      = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (settle_cnt == SETTLE_LAST) begin
                    capture   = 1'b1;
                    state_nxt = S_RES;
                end
            end
            S_RES: begin
                // No bypass: the next op byte is only accepted once back in S_OP.
                if (out_xfer) begin
                    state_nxt = S_OP;
                end
            end
            default: begin
                state_nxt = S_OP;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            settle_cnt <= '0;
        end else if (ld_b) begin
            settle_cnt <= '0;
        end else if (state == S_EXEC) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    // Operand registers hold their value after capture until their own byte arrives.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            AU_CONTROL <= '0;
            AU_A       <= '0;
            AU_B       <= '0;
        end else begin
            if (ld_op) begin
                AU_CONTROL <= IN_DATA[1:0] & OP_MASK;
            end
            if (ld_a) begin
                AU_A <= IN_DATA;
            end
            if (ld_b) begin
                AU_B <= IN_DATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
        end else if (capture) begin
            OUT_VALID <= 1'b1;
        end else if (out_xfer) begin
            OUT_VALID <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OP_COUNT <= '0;
        end else if (out_xfer && (OP_COUNT != 8'hFF)) begin
            OP_COUNT <= OP_COUNT + 8'd1;
        end
    end

    au_result_reg #(.W(WIDTH)) u_res_r (
        .clk   (CLK),
        .rst_n (RST_N),
        .ld    (capture),
        .d     (AU_R),
        .q     (OUT_R)
    );

    au_result_reg #(.W(1)) u_res_c (
        .clk   (CLK),
        .rst_n (RST_N),
        .ld    (capture),
        .d     (AU_C),
        .q     (OUT_C)
    );

    au_result_reg #(.W(1)) u_res_z (
        .clk   (CLK),
        .rst_n (RST_N),
        .ld    (capture),
        .d     (au_zero),
        .q     (OUT_Z)
    );

endmodule

// File: tb/tb_au_op_sequencer.sv
// Directed bench for au_op_sequencer: one instance with the default settle
// interval and one with SETTLE_CYCLES=3, AU result/carry driven by the bench.
module tb_au_op_sequencer;

    logic       clk;
    logic       rst_n;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] au_a;
    logic [7:0] au_b;
    logic [1:0] au_control;
    logic [7:0] au_r;
    logic       au_c;
    logic [7:0] out_r;
    logic       out_c;
    logic       out_z;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] op_count;

    logic [7:0] in_data3;
    logic       in_valid3;
    logic       in_ready3;
    logic [7:0] au_a3;
    logic [7:0] au_b3;
    logic [1:0] au_control3;
    logic [7:0] au_r3;
    logic       au_c3;
    logic [7:0] out_r3;
    logic       out_c3;
    logic       out_z3;
    logic       out_valid3;
    logic       out_ready3;
    logic       busy3;
    logic [7:0] op_count3;

    int total = 0;
    int bad   = 0;

    au_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .IN_DATA    (in_data),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .AU_A       (au_a),
        .AU_B       (au_b),
        .AU_CONTROL (au_control),
        .AU_R       (au_r),
        .AU_C       (au_c),
        .OUT_R      (out_r),
        .OUT_C      (out_c),
        .OUT_Z      (out_z),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .BUSY       (busy),
        .OP_COUNT   (op_count)
    );

    au_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3)) dut3 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .IN_DATA    (in_data3),
        .IN_VALID   (in_valid3),
        .IN_READY   (in_ready3),
        .AU_A       (au_a3),
        .AU_B       (au_b3),
        .AU_CONTROL (au_control3),
        .AU_R       (au_r3),
        .AU_C       (au_c3),
        .OUT_R      (out_r3),
        .OUT_C      (out_c3),
        .OUT_Z      (out_z3),
        .OUT_VALID  (out_valid3),
        .OUT_READY  (out_ready3),
        .BUSY       (busy3),
        .OP_COUNT   (op_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte and holds it until accepted (bounded wait).
    task automatic send_byte(input bit sel, input logic [7:0] b);
        int unsigned n = 0;
        if (sel) begin in_data3 = b; in_valid3 = 1'b1; end
        else     begin in_data  = b; in_valid  = 1'b1; end
        while (!(sel ? in_ready3 : in_ready) && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL send_byte_timeout sel=%0d byte=%02h: in_ready never rose", sel, b);
        end
        step();
        if (sel) in_valid3 = 1'b0;
        else     in_valid  = 1'b0;
    endtask

    task automatic wait_valid(input bit sel);
        int unsigned n = 0;
        while (!(sel ? out_valid3 : out_valid) && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL wait_valid_timeout sel=%0d: out_valid never rose", sel);
        end
    endtask

    task automatic handshake(input bit sel);
        if (sel) out_ready3 = 1'b1;
        else     out_ready  = 1'b1;
        step();
        if (sel) out_ready3 = 1'b0;
        else     out_ready  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
        end
        total++;
        if ({au_a, au_b, au_control, out_r, out_c, out_z, op_count} !== 36'h0) begin
            bad++;
            $display("FAIL reset_regs: got a=%02h b=%02h ctl=%b r=%02h c=%b z=%b cnt=%0d want all 0",
                     au_a, au_b, au_control, out_r, out_c, out_z, op_count);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        au_r = 8'h03;
        au_c = 1'b0;
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h02);
        send_byte(1'b0, 8'h01);
        total++;
        if ({au_control, au_a, au_b} !== {2'b00, 8'h02, 8'h01}) begin
            bad++;
            $display("FAIL basic_operands: got ctl=%b a=%02h b=%02h want 00 02 01", au_control, au_a, au_b);
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_exec: got vld=%b rdy=%b want 0 0", out_valid, in_ready);
        end
        step();
        total++;
        if ({out_valid, out_r, out_c, out_z} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL basic_result: got vld=%b r=%02h c=%b z=%b want 1 03 0 0", out_valid, out_r, out_c, out_z);
        end
        handshake(1'b0);
        total++;
        if (op_count !== 8'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_handshake: got cnt=%0d vld=%b rdy=%b want 1 0 1", op_count, out_valid, in_ready);
        end
    endtask

    task automatic test_zero_carry();
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        total++;
        if (op_count !== 8'd1) begin
            bad++;
            $display("FAIL idle_out_ready: got cnt=%0d want 1", op_count);
        end
        au_r = 8'h00;
        au_c = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send_byte(1'b0, (k == 0) ? 8'h01 : 8'hFD);
            send_byte(1'b0, 8'h08);
            send_byte(1'b0, 8'h01);
            wait_valid(1'b0);
            total++;
            if ({au_control, out_r, out_c, out_z} !== {2'b01, 8'h00, 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL zero_carry_%0d: got ctl=%b r=%02h c=%b z=%b want 01 00 1 1",
                         k, au_control, out_r, out_c, out_z);
            end
            handshake(1'b0);
        end
        total++;
        if (op_count !== 8'd3) begin
            bad++;
            $display("FAIL zero_carry_count: got %0d want 3", op_count);
        end
    endtask

    task automatic test_backpressure();
        au_r = 8'h5A;
        au_c = 1'b1;
        send_byte(1'b0, 8'h02);
        send_byte(1'b0, 8'hC3);
        send_byte(1'b0, 8'h3C);
        wait_valid(1'b0);
        in_data  = 8'h77;
        in_valid = 1'b1;
        au_r     = 8'h00;
        au_c     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if ({out_valid, in_ready, out_r, out_c, out_z, au_control} !== {1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 2'b10}) begin
                bad++;
                $display("FAIL backpressure_hold_%0d: got vld=%b rdy=%b r=%02h c=%b z=%b ctl=%b want 1 0 5a 1 0 10",
                         k, out_valid, in_ready, out_r, out_c, out_z, au_control);
            end
        end
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_no_bypass: got rdy=%b want 0", in_ready);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, busy, op_count} !== {1'b0, 1'b1, 1'b0, 8'd4}) begin
            bad++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b busy=%b cnt=%0d want 0 1 0 4",
                     out_valid, in_ready, busy, op_count);
        end
    endtask

    task automatic test_input_gaps();
        logic [5:0] pattern;
        logic [7:0] bytes [3];
        int unsigned idx;
        int unsigned accepted;
        pattern  = 6'b101001;
        bytes[0] = 8'h02;
        bytes[1] = 8'h11;
        bytes[2] = 8'h22;
        idx      = 0;
        accepted = 0;
        au_r     = 8'h33;
        au_c     = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = pattern[k];
            in_data  = pattern[k] ? bytes[idx] : 8'hEE;
            if (in_valid && in_ready) begin
                accepted++;
                idx++;
            end
            step();
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL gaps_busy_%0d: got %b want 1", k, busy);
            end
        end
        in_valid = 1'b0;
        total++;
        if (accepted != 3 || {au_control, au_a, au_b} !== {2'b10, 8'h11, 8'h22}) begin
            bad++;
            $display("FAIL gaps_bytes: got n=%0d ctl=%b a=%02h b=%02h want 3 10 11 22", accepted, au_control, au_a, au_b);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_r !== 8'h33 || busy !== 1'b1) begin
            bad++;
            $display("FAIL gaps_result: got vld=%b r=%02h busy=%b want 1 33 1", out_valid, out_r, busy);
        end
        handshake(1'b0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL gaps_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_settle3();
        au_r3 = 8'hAA;
        au_c3 = 1'b0;
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h01);
        send_byte(1'b1, 8'h02);
        step();
        total++;
        if (out_valid3 !== 1'b0) begin
            bad++;
            $display("FAIL settle3_edge1: got vld=%b want 0", out_valid3);
        end
        step();
        total++;
        if (out_valid3 !== 1'b0) begin
            bad++;
            $display("FAIL settle3_edge2: got vld=%b want 0", out_valid3);
        end
        au_r3 = 8'h55;
        step();
        total++;
        if ({out_valid3, out_r3, out_z3} !== {1'b1, 8'h55, 1'b0}) begin
            bad++;
            $display("FAIL settle3_capture: got vld=%b r=%02h z=%b want 1 55 0", out_valid3, out_r3, out_z3);
        end
        handshake(1'b1);
        total++;
        if (op_count3 !== 8'd1 || in_ready3 !== 1'b1) begin
            bad++;
            $display("FAIL settle3_handshake: got cnt=%0d rdy=%b want 1 1", op_count3, in_ready3);
        end
    endtask

    task automatic test_reset_midframe_and_saturation();
        send_byte(1'b0, 8'h03);
        send_byte(1'b0, 8'h9C);
        total++;
        if (au_a !== 8'h9C || au_control !== 2'b11) begin
            bad++;
            $display("FAIL midframe_load: got a=%02h ctl=%b want 9c 11", au_a, au_control);
        end
        rst_n = 1'b0;
        #2;
        total++;
        if ({au_a, au_control, in_ready, busy, op_count} !== {8'h00, 2'b00, 1'b1, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL midframe_reset: got a=%02h ctl=%b rdy=%b busy=%b cnt=%0d want 00 00 1 0 0",
                     au_a, au_control, in_ready, busy, op_count);
        end
        step();
        rst_n = 1'b1;
        step();
        au_r = 8'h01;
        for (int k = 1; k <= 256; k++) begin
            send_byte(1'b0, 8'h00);
            send_byte(1'b0, 8'(k));
            send_byte(1'b0, 8'h01);
            wait_valid(1'b0);
            handshake(1'b0);
            if (k == 254 || k == 255 || k == 256) begin
                total++;
                if (op_count !== ((k == 254) ? 8'd254 : 8'd255)) begin
                    bad++;
                    $display("FAIL saturation_%0d: got cnt=%0d want %0d", k, op_count, (k == 254) ? 254 : 255);
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        au_r       = 8'h00;
        au_c       = 1'b0;
        in_data3   = 8'h00;
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;
        au_r3      = 8'h00;
        au_c3      = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_zero_carry();
        test_backpressure();
        test_input_gaps();
        test_settle3();
        test_reset_midframe_and_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
